// File: rtl/bpio_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bpio_cmd_sequencer_pkg
// Shared definitions for the bus-pirate style command sequencer: opcode
// values, error codes, the sequencer state encoding and a helper that sizes
// the shared delay/timeout down-counter. The opcode and error-code values are
// also what the MCU register map exposes, so keep them in sync with it.
// ---------------------------------------------------------------------------
package bpio_cmd_sequencer_pkg;

  // Command opcodes, carried in cmd_data[15:8]
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_XFER  = 8'h02;
  localparam logic [7:0] OP_DELAY = 8'h03;

  // Values reported on err_code
  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_BAD_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_PE_TIMEOUT  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seqState_t;

  // The down-counter has to hold both the longest DELAY load and the
  // peripheral timeout, so it is sized for whichever is larger.
  function automatic int timerWidth(input int prescale, input int timeout);
    int delayBits;
    int timeoutBits;
    delayBits   = $clog2(255 * prescale + 1);
    timeoutBits = $clog2(timeout + 1);
    return (delayBits > timeoutBits) ? delayBits : timeoutBits;
  endfunction

endpackage

// File: rtl/bpio_seq_timer.sv
// ---------------------------------------------------------------------------
// bpio_seq_timer
// Loadable down-counter with a zero flag. The sequencer uses it both for
// DELAY commands and for the peripheral-done timeout; those never overlap.
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset (count -> 0)
//   i_load       load i_loadValue this cycle (has priority over decrement)
//   i_loadValue  value to load
//   i_decrement  count down by one; holds at zero instead of wrapping
//   o_zero       count is zero
// ---------------------------------------------------------------------------
module bpio_seq_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_decrement,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load wins over decrement; the count parks at zero so a state that
  // lingers one cycle past expiry cannot wrap around to the maximum value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_decrement && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bpio_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bpio_cmd_sequencer
// Pops 16-bit command words ({opcode, argument}) from the command FIFO and
// executes them against the byte-shift peripheral engine, pushing received
// bytes into the result FIFO.
// Ports:
//   clock, reset            single clock domain, synchronous active-high reset
//   run                     1 = fetch new commands, 0 = idle after current one
//   clear_err               clears err/err_code and leaves the ERROR state
//   cmd_nempty/cmd_pop      command FIFO handshake, cmd_data valid after pop
//   cmd_data[15:0]          [15:8] opcode, [7:0] argument
//   res_full/res_push       result FIFO handshake
//   res_data[7:0]           received byte, valid with res_push
//   pe_start/pe_tx[7:0]     start a byte shift; pe_tx held until pe_done
//   pe_done/pe_rx[7:0]      shift complete, pe_rx valid that cycle
//   idle                    sequencer is in IDLE
//   err/err_code[1:0]       sticky error flag and cause
//   cmd_count[15:0]         commands completed since reset (wraps)
// ---------------------------------------------------------------------------
module bpio_cmd_sequencer
  import bpio_cmd_sequencer_pkg::*;
#(
  parameter int DELAY_PRESCALE = 16,
  parameter int TIMEOUT        = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear_err,
  input  logic        cmd_nempty,
  output logic        cmd_pop,
  input  logic [15:0] cmd_data,
  input  logic        res_full,
  output logic        res_push,
  output logic [7:0]  res_data,
  output logic        pe_start,
  output logic [7:0]  pe_tx,
  input  logic        pe_done,
  input  logic [7:0]  pe_rx,
  output logic        idle,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] cmd_count
);

  localparam int TW = timerWidth(DELAY_PRESCALE, TIMEOUT);

  seqState_t   r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_arg;
  logic [7:0]  r_rx;
  logic        r_held;
  logic        r_cmdPop;
  logic        r_peStart;
  logic        r_resPush;
  logic        r_err;
  logic [1:0]  r_errCode;
  logic [15:0] r_cmdCount;

  logic [7:0]    w_op;
  logic [7:0]    w_arg;
  logic          w_tmrLoad;
  logic [TW-1:0] w_tmrLoadValue;
  logic          w_tmrDecrement;
  logic          w_tmrZero;

  // An XFER stalled on a full result FIFO keeps re-deciding from the copy
  // latched on its first DECODE cycle, so the FIFO read port is free to move.
  assign w_op  = r_held ? r_op  : cmd_data[15:8];
  assign w_arg = r_held ? r_arg : cmd_data[7:0];

  // Timer control. Loads are N-1 so that the owning state lasts exactly N
  // cycles and exits on the zero flag: DELAY for arg*DELAY_PRESCALE cycles,
  // WAIT for TIMEOUT cycles.
  always_comb begin
    w_tmrLoad      = 1'b0;
    w_tmrLoadValue = '0;
    w_tmrDecrement = 1'b0;
    if ((r_state == ST_DECODE) && (w_op == OP_DELAY) && (w_arg != 8'd0)) begin
      w_tmrLoad      = 1'b1;
      w_tmrLoadValue = TW'(w_arg) * TW'(DELAY_PRESCALE) - TW'(1);
    end else if (r_state == ST_ISSUE) begin
      w_tmrLoad      = 1'b1;
      w_tmrLoadValue = TW'(TIMEOUT - 1);
    end else if ((r_state == ST_WAIT) || (r_state == ST_DELAY)) begin
      w_tmrDecrement = 1'b1;
    end
  end

  bpio_seq_timer #(.WIDTH(TW)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_tmrLoad),
    .i_loadValue (w_tmrLoadValue),
    .i_decrement (w_tmrDecrement),
    .o_zero      (w_tmrZero)
  );

  // Main sequencer FSM. The strobes are registered: each one is raised on
  // the transition into the state that owns it, so it is high for exactly
  // that state's single cycle. Reset drops any strobe in flight and discards
  // a word already popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NOP;
      r_arg      <= 8'd0;
      r_rx       <= 8'd0;
      r_held     <= 1'b0;
      r_cmdPop   <= 1'b0;
      r_peStart  <= 1'b0;
      r_resPush  <= 1'b0;
      r_err      <= 1'b0;
      r_errCode  <= ERR_NONE;
      r_cmdCount <= 16'd0;
    end else begin
      r_cmdPop  <= 1'b0;
      r_peStart <= 1'b0;
      r_resPush <= 1'b0;
      if (clear_err) begin
        r_err     <= 1'b0;
        r_errCode <= ERR_NONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (run && cmd_nempty && !r_err) begin
            r_state  <= ST_FETCH;
            r_cmdPop <= 1'b1;
          end
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_op   <= w_op;
          r_arg  <= w_arg;
          r_held <= (w_op == OP_XFER) && res_full;
          case (w_op)
            OP_NOP:   r_state <= ST_DONE;
            OP_WRITE: begin
              r_state   <= ST_ISSUE;
              r_peStart <= 1'b1;
            end
            OP_XFER: begin
              if (!res_full) begin
                r_state   <= ST_ISSUE;
                r_peStart <= 1'b1;
              end
            end
            OP_DELAY: r_state <= (w_arg == 8'd0) ? ST_DONE : ST_DELAY;
            default: begin
              r_state   <= ST_ERROR;
              r_err     <= 1'b1;
              r_errCode <= ERR_BAD_OPCODE;
            end
          endcase
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (pe_done) begin
            r_rx <= pe_rx;
            if (r_op == OP_XFER) begin
              r_state   <= ST_PUSH;
              r_resPush <= 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end else if (w_tmrZero) begin
            r_state   <= ST_ERROR;
            r_err     <= 1'b1;
            r_errCode <= ERR_PE_TIMEOUT;
          end
        end
        ST_PUSH:  r_state <= ST_DONE;
        ST_DELAY: begin
          if (w_tmrZero) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_cmdCount <= r_cmdCount + 16'd1;
          r_state    <= ST_IDLE;
        end
        ST_ERROR: begin
          if (clear_err) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_pop   = r_cmdPop;
  assign pe_start  = r_peStart;
  assign pe_tx     = r_arg;
  assign res_push  = r_resPush;
  assign res_data  = r_rx;
  assign idle      = (r_state == ST_IDLE);
  assign err       = r_err;
  assign err_code  = r_errCode;
  assign cmd_count = r_cmdCount;

endmodule

// File: tb/tb_bpio_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bpio_cmd_sequencer
// Directed bench for bpio_cmd_sequencer. A command-FIFO model and a
// peripheral model respond to the DUT; expected pe_start / res_push events
// are queued by the stimulus and consumed by a separate monitor.
// ---------------------------------------------------------------------------
module tb_bpio_cmd_sequencer;

  localparam int PRESCALE = 16;
  localparam int TMO      = 64;
  localparam int K_START  = 0;
  localparam int K_PUSH   = 1;
  localparam int SEL_COUNT = 0;
  localparam int SEL_ERR   = 1;
  localparam int SEL_POP   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } evT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        clear_err = 1'b0;
  logic        cmd_nempty = 1'b0;
  logic [15:0] cmd_data = 16'd0;
  logic        res_full = 1'b0;
  logic        pe_done = 1'b0;
  logic [7:0]  pe_rx = 8'd0;
  logic        cmd_pop;
  logic        res_push;
  logic [7:0]  res_data;
  logic        pe_start;
  logic [7:0]  pe_tx;
  logic        idle;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] cmd_count;

  int          testsRun = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pushCycle = 0;
  int          lastPop = 0;
  int          prevPop = 0;
  int          popCount = 0;
  int          lastDone = 0;
  int          peDelay = 3;
  int          peCnt = 0;
  logic        peRespond = 1'b1;
  logic [7:0]  peRx = 8'h00;
  logic [15:0] cmdQ[$];
  evT          expQ[$];

  bpio_cmd_sequencer #(.DELAY_PRESCALE(PRESCALE), .TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .clear_err  (clear_err),
    .cmd_nempty (cmd_nempty),
    .cmd_pop    (cmd_pop),
    .cmd_data   (cmd_data),
    .res_full   (res_full),
    .res_push   (res_push),
    .res_data   (res_data),
    .pe_start   (pe_start),
    .pe_tx      (pe_tx),
    .pe_done    (pe_done),
    .pe_rx      (pe_rx),
    .idle       (idle),
    .err        (err),
    .err_code   (err_code),
    .cmd_count  (cmd_count)
  );

  always #5 clock = ~clock;

  // Cycle number; sampled on negedges, so cycle k is the interval after
  // the k-th rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    cmdQ.push_back(word);
    pushCycle = cyc;
  endtask

  task automatic expectEvent(input int kind, input logic [7:0] data, input int atCyc);
    evT e;
    e.kind = kind;
    e.data = data;
    e.cyc  = atCyc;
    expQ.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Idle"}, 32'(idle), 32'd1);
    checkOutput({tag, "Zeros"},
                32'({cmd_pop, pe_start, res_push, err, err_code, pe_tx, res_data}), 32'd0);
    checkOutput({tag, "Count"}, 32'(cmd_count), 32'd0);
  endtask

  function automatic int probe(input int sel);
    if (sel == SEL_COUNT) return int'(cmd_count);
    if (sel == SEL_ERR) return int'(err);
    return int'(cmd_pop);
  endfunction

  // Bounded wait on a DUT output; an expired bound counts as a failure.
  task automatic waitFor(input string name, input int sel, input int target,
                         input int budget, output int atCyc);
    int n;
    n = 0;
    atCyc = -1;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (probe(sel) == target) begin
        atCyc = cyc;
        break;
      end
    end
    if (atCyc < 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL %s: timed out after %0d cycles, value %0d, required %0d",
               name, budget, probe(sel), target);
    end
  endtask

  // Command FIFO model: hands out the next word after each pop. Runs just
  // after the negedge so words queued on that negedge are seen at once.
  always @(negedge clock) begin
    #1;
    if (cmd_pop) begin
      checkOutput("popNonEmpty", 32'(cmdQ.size() != 0), 32'd1);
      if (cmdQ.size() != 0) cmd_data = cmdQ.pop_front();
      prevPop = lastPop;
      lastPop = cyc;
      popCount++;
    end
    cmd_nempty = (cmdQ.size() != 0);
  end

  // Peripheral model: answers each pe_start with pe_done peDelay cycles
  // later. pe_rx carries a decoy value whenever pe_done is low.
  always @(negedge clock) begin
    pe_done = 1'b0;
    pe_rx   = ~peRx;
    if (reset) begin
      peCnt = 0;
    end else begin
      if (peCnt > 0) begin
        peCnt--;
        if (peCnt == 0) begin
          pe_done  = 1'b1;
          pe_rx    = peRx;
          lastDone = cyc;
        end
      end
      if (pe_start && peRespond) peCnt = peDelay;
    end
  end

  task automatic checkEvent(input int kind, input logic [7:0] data);
    evT e;
    if (expQ.size() == 0) begin
      testsRun++;
      failures++;
      $display("[TB] FAIL unexpectedEvent: kind %0d data 0x%0h at cycle %0d, required none",
               kind, data, cyc);
    end else begin
      e = expQ.pop_front();
      checkOutput("eventKind", 32'(kind), 32'(e.kind));
      checkOutput("eventData", 32'(data), 32'(e.data));
      if (e.cyc >= 0) checkOutput("eventCycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_PUSH) checkOutput("pushAfterDone", 32'(cyc), 32'(lastDone + 1));
    end
  endtask

  // Scoreboard monitor: every start/push the DUT presents is matched
  // against the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (pe_start) checkEvent(K_START, pe_tx);
      if (res_push) checkEvent(K_PUSH, res_data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int pops0;

    repeat (3) @(negedge clock);
    checkResetOutputs("reset");
    reset = 1'b0;
    run   = 1'b1;

    // WRITE: one shift of 0x55, no push
    peDelay = 3; peRx = 8'hAA; peRespond = 1'b1;
    expectEvent(K_START, 8'h55, -1);
    applyStimulus(16'h0155);
    waitFor("t1Count", SEL_COUNT, 1, 60, t);
    checkOutput("t1PopLatency", 32'(lastPop - pushCycle), 32'd1);
    checkOutput("t1Latency", 32'(t - lastPop), 32'd7);
    checkOutput("t1Idle", 32'(idle), 32'd1);

    // XFER: received 0x3C pushed the cycle after pe_done
    peDelay = 2; peRx = 8'h3C;
    expectEvent(K_START, 8'hA5, -1);
    expectEvent(K_PUSH, 8'h3C, -1);
    applyStimulus(16'h02A5);
    waitFor("t2Count", SEL_COUNT, 2, 60, t);
    checkOutput("t2Latency", 32'(t - lastPop), 32'd7);

    // XFER held in DECODE while the result FIFO is full
    peDelay = 1; peRx = 8'h99;
    res_full = 1'b1;
    applyStimulus(16'h0204);
    repeat (10) @(negedge clock);
    res_full = 1'b0;
    expectEvent(K_START, 8'h04, cyc + 1);
    expectEvent(K_PUSH, 8'h99, -1);
    waitFor("t3Count", SEL_COUNT, 3, 30, t);

    // DELAY 5 -> 80 cycles in DELAY; DELAY 0 -> straight to DONE
    applyStimulus(16'h0305);
    waitFor("t4Count", SEL_COUNT, 4, 150, t);
    checkOutput("t4Delay80", 32'(t - lastPop), 32'd83);
    applyStimulus(16'h0300);
    waitFor("t4ZeroCount", SEL_COUNT, 5, 30, t);
    checkOutput("t4Delay0", 32'(t - lastPop), 32'd3);

    // Back-to-back NOPs: 4 cycles pop to pop
    applyStimulus(16'h0000);
    applyStimulus(16'h0000);
    waitFor("nopCount", SEL_COUNT, 7, 30, t);
    checkOutput("nopPopToPop", 32'(lastPop - prevPop), 32'd4);

    // Bad opcode stops the sequencer until clear_err
    pops0 = popCount;
    applyStimulus(16'h7F00);
    applyStimulus(16'h0155);
    waitFor("t5Err", SEL_ERR, 1, 20, t);
    checkOutput("t5ErrLatency", 32'(t - lastPop), 32'd2);
    checkOutput("t5ErrCode", 32'(err_code), 32'd1);
    repeat (10) @(negedge clock);
    checkOutput("t5NoPop", 32'(popCount - pops0), 32'd1);
    checkOutput("t5NotIdle", 32'(idle), 32'd0);
    checkOutput("t5CountHeld", 32'(cmd_count), 32'd7);
    peDelay = 3;
    expectEvent(K_START, 8'h55, -1);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checkOutput("t5Cleared", 32'({err, err_code}), 32'd0);
    waitFor("t5Resume", SEL_COUNT, 8, 40, t);
    checkOutput("t5Popped", 32'(popCount - pops0), 32'd2);

    // run dropped mid-command: the DELAY completes, the NOP waits
    pops0 = popCount;
    applyStimulus(16'h0301);
    applyStimulus(16'h0000);
    waitFor("runPop", SEL_POP, 1, 10, t);
    run = 1'b0;
    waitFor("runFinish", SEL_COUNT, 9, 60, t);
    repeat (5) @(negedge clock);
    checkOutput("runHeldPops", 32'(popCount - pops0), 32'd1);
    checkOutput("runHeldIdle", 32'(idle), 32'd1);
    run = 1'b1;
    waitFor("runResume", SEL_COUNT, 10, 20, t);

    // clear_err outside ERROR changes nothing
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checkOutput("clrIdle", 32'({idle, err, cmd_count}), 32'({1'b1, 1'b0, 16'd10}));

    // Peripheral timeout
    peRespond = 1'b0;
    expectEvent(K_START, 8'h11, -1);
    applyStimulus(16'h0111);
    waitFor("t6Err", SEL_ERR, 1, TMO + 20, t);
    checkOutput("t6Timeout", 32'(t - lastPop), 32'(TMO + 3));
    checkOutput("t6ErrCode", 32'(err_code), 32'd2);
    checkOutput("t6CountHeld", 32'(cmd_count), 32'd10);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checkOutput("t6Cleared", 32'({idle, err}), 32'b10);

    // Reset while waiting on the peripheral
    expectEvent(K_START, 8'h11, -1);
    applyStimulus(16'h0111);
    waitFor("t6Pop", SEL_POP, 1, 10, t);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkResetOutputs("midWait");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
